accel_host_sequencer: RTL

- Host-side initiator that drives a complete inference job into the ai_accelerator control, weight, ifmap and ofmap ports.
- Accepts one job descriptor, streams weights into accelerator memory, pulses start, and feeds ifmap vectors under valid/ready.
- Collects the single ofmap word, waits for done, and returns the result (or a timeout error) on a result stream.
- Sits between the host DMA/FIFOs and the accelerator top.

---
 rtl/accel_host_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/accel_host_sequencer.sv
// Host-side job sequencer for the ai_accelerator: loads weights, pulses start, streams
// ifmap vectors, collects the single ofmap word and returns it (or a timeout) to the host.
module accel_host_sequencer #(
  parameter int ARRAY_SIZE     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_ADDR_WIDTH = 14,
  parameter int WDATA_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [MEM_ADDR_WIDTH-1:0]        cmd_w_base,
  input  logic [MEM_ADDR_WIDTH-1:0]        cmd_w_count,
  input  logic [7:0]                       cmd_ifmap_count,
  input  logic [1:0]                       cmd_act_type,
  input  logic [WDATA_WIDTH-1:0]           w_src_data,
  input  logic                             w_src_valid,
  output logic                             w_src_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] x_src_data,
  input  logic                             x_src_valid,
  output logic                             x_src_ready,
  output logic                             acc_start,
  output logic [1:0]                       acc_activation_type,
  output logic [7:0]                       acc_layer_size,
  input  logic                             acc_done,
  input  logic                             acc_busy,
  output logic [MEM_ADDR_WIDTH-1:0]        acc_weight_addr,
  output logic [WDATA_WIDTH-1:0]           acc_weight_data,
  output logic                             acc_weight_we,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] acc_ifmap_data,
  output logic                             acc_ifmap_valid,
  input  logic                             acc_ifmap_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] acc_ofmap_data,
  input  logic                             acc_ofmap_valid,
  output logic                             acc_ofmap_ready,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] res_data,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic                             res_error,
  output logic                             seq_busy
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_START, S_STREAM, S_WAIT_OUT, S_RESULT
  } state_t;

  state_t                    state, state_next;
  logic [MEM_ADDR_WIDTH-1:0] w_addr;
  logic [MEM_ADDR_WIDTH-1:0] w_rem;
  logic [7:0]                x_rem;
  logic                      done_seen;
  logic                      captured;
  logic [WDW-1:0]            wd_cnt;

  logic cmd_hs, w_hs, x_hs, o_hs, res_hs;
  logic x_live, active, wd_expired;

  always_comb begin
    cmd_ready       = (state == S_IDLE);
    seq_busy        = (state != S_IDLE);
    w_src_ready     = (state == S_LOAD_W);
    x_live          = (state == S_STREAM) && (x_rem != 8'd0);
    acc_ifmap_data  = x_src_data;
    acc_ifmap_valid = x_src_valid && x_live;
    x_src_ready     = acc_ifmap_ready && x_live;
    acc_ofmap_ready = (state == S_WAIT_OUT);
    acc_start       = (state == S_START) && !acc_busy;
    res_valid       = (state == S_RESULT);

    cmd_hs = cmd_valid && cmd_ready;
    w_hs   = w_src_valid && w_src_ready;
    x_hs   = acc_ifmap_valid && acc_ifmap_ready;
    o_hs   = acc_ofmap_valid && acc_ofmap_ready;
    res_hs = res_valid && res_ready;

    active     = (state == S_LOAD_W) || (state == S_START) ||
                 (state == S_STREAM) || (state == S_WAIT_OUT);
    wd_expired = active && (wd_cnt == WDW'(TIMEOUT_CYCLES));

    state_next = state;
    case (state)
      S_IDLE:     if (cmd_hs) state_next = (cmd_w_count != '0) ? S_LOAD_W : S_START;
      S_LOAD_W:   if (w_hs && (w_rem == MEM_ADDR_WIDTH'(1))) state_next = S_START;
      S_START:    if (!acc_busy) state_next = S_STREAM;
      S_STREAM:   if ((x_rem == 8'd0) || (x_hs && (x_rem == 8'd1))) state_next = S_WAIT_OUT;
      // Valid and done may land in the same cycle, so look at this cycle's events too
      S_WAIT_OUT: if ((captured || o_hs) && (done_seen || acc_done)) state_next = S_RESULT;
      S_RESULT:   if (res_hs) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
    if (wd_expired) state_next = S_RESULT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= S_IDLE;
      w_addr              <= '0;
      w_rem               <= '0;
      x_rem               <= '0;
      done_seen           <= 1'b0;
      captured            <= 1'b0;
      wd_cnt              <= '0;
      acc_weight_we       <= 1'b0;
      acc_weight_addr     <= '0;
      acc_weight_data     <= '0;
      acc_activation_type <= '0;
      acc_layer_size      <= '0;
      res_data            <= '0;
      res_error           <= 1'b0;
    end else begin
      state         <= state_next;
      acc_weight_we <= w_hs;

      if (cmd_hs) begin
        w_addr              <= cmd_w_base;
        w_rem               <= cmd_w_count;
        x_rem               <= cmd_ifmap_count;
        acc_activation_type <= cmd_act_type;
        acc_layer_size      <= cmd_ifmap_count;
        done_seen           <= 1'b0;
        captured            <= 1'b0;
        res_error           <= 1'b0;
      end

      // Address wraps naturally at 2^MEM_ADDR_WIDTH
      if (w_hs) begin
        acc_weight_addr <= w_addr;
        acc_weight_data <= w_src_data;
        w_addr          <= w_addr + MEM_ADDR_WIDTH'(1);
        w_rem           <= w_rem - MEM_ADDR_WIDTH'(1);
      end

      if (x_hs) x_rem <= x_rem - 8'd1;

      if (o_hs && !captured) begin
        res_data <= acc_ofmap_data;
        captured <= 1'b1;
      end
      if ((state == S_WAIT_OUT) && acc_done) done_seen <= 1'b1;

      if (wd_expired) begin
        res_data  <= '0;
        res_error <= 1'b1;
      end

      if (res_hs) begin
        done_seen <= 1'b0;
        captured  <= 1'b0;
      end

      // Any forward progress or state change restarts the idle window
      if (!active || (state_next != state) || w_hs || x_hs || o_hs)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + WDW'(1);
    end
  end

endmodule
